// File: rtl/ps2_kb_writer_pkg.sv
// Shared keyboard-event definitions: info-word address, event field positions,
// PS/2 prefix codes and the frame receiver state type.
package ps2_kb_writer_pkg;

  localparam logic [31:0] KB_INFO_ADDR_DEFAULT = 32'h0050_0000;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned EV_CODE_LSB = 0;
  localparam int unsigned EV_EXT_BIT  = 8;
  localparam int unsigned EV_BRK_BIT  = 9;
  localparam int unsigned EV_SEQ_LSB  = 16;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  function automatic logic [31:0] make_event(input logic [15:0] seq,
                                             input logic        brk,
                                             input logic        ext,
                                             input logic [7:0]  code);
    logic [31:0] w;
    w = '0;
    w[EV_CODE_LSB +: 8]  = code;
    w[EV_EXT_BIT]        = ext;
    w[EV_BRK_BIT]        = brk;
    w[EV_SEQ_LSB +: 16]  = seq;
    return w;
  endfunction

endpackage

// File: rtl/ps2_kb_writer_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect,
// 11-bit frame FSM, inactivity timeout and odd-parity/stop check.
module ps2_frame_rx
  import ps2_kb_writer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;

  frame_state_t state, state_nx;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic          parity_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          stop_edge;
  logic          frame_ok;

  // Synchronisers idle high so reset does not fabricate a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall    = clk_prev & ~clk_sync;
  // An edge in the same cycle as the final timeout count takes precedence.
  assign tmo_hit = (state != FR_IDLE) && !fall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FR_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (tmo_hit) begin
      state_nx = FR_IDLE;
    end else if (fall) begin
      unique case (state)
        FR_IDLE:   if (!data_sync) state_nx = FR_DATA;
        FR_DATA:   if (bit_cnt == 3'd7) state_nx = FR_PARITY;
        FR_PARITY: state_nx = FR_STOP;
        FR_STOP:   state_nx = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      if (fall || state == FR_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (fall) begin
        unique case (state)
          FR_IDLE:   bit_cnt <= '0;
          FR_DATA: begin
            shift_q <= {data_sync, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          FR_PARITY: parity_q <= data_sync;
          FR_STOP:   ;
        endcase
      end
    end
  end

  always_comb begin
    stop_edge  = (state == FR_STOP) && fall;
    frame_ok   = data_sync && ((^shift_q) ^ parity_q);
    byte_valid = stop_edge && frame_ok;
    frame_err  = stop_edge && !frame_ok;
    rx_byte    = shift_q;
  end

endmodule

// File: rtl/ps2_kb_writer.sv
// PS/2 keyboard event producer: folds E0/F0 prefixes into one event word and
// writes it, tagged with a sequence number, to the keyboard info register.
module ps2_kb_writer
  import ps2_kb_writer_pkg::*;
#(
  parameter logic [31:0] KB_INFO_ADDR   = KB_INFO_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] kb_wraddr,
  output logic [31:0] kb_wrdata,
  output logic        kb_we,
  output logic [7:0]  err_cnt
);

  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        frame_err;
  logic        ext, brk;
  logic [15:0] seq;
  logic [15:0] seq_nx;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign kb_wraddr = KB_INFO_ADDR;
  assign seq_nx    = seq + 16'd1;

  // Prefix flags are sticky until an event is written or a bad frame arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_we     <= 1'b0;
      kb_wrdata <= '0;
      seq       <= '0;
      err_cnt   <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else begin
      kb_we <= 1'b0;
      if (frame_err) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          kb_we     <= 1'b1;
          kb_wrdata <= make_event(seq_nx, brk, ext, rx_byte);
          seq       <= seq_nx;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kb_writer.sv
// Bench for ps2_kb_writer: drives PS/2 frames and compares every write and
// the error counter against a byte-level event model.
module tb_ps2_kb_writer;

  localparam logic [31:0] ADDR = 32'h0050_0010;
  localparam int unsigned TMO  = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] kb_wraddr;
  logic [31:0] kb_wrdata;
  logic        kb_we;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int half = 8;

  logic [31:0] got_q[$];
  logic        we_prev = 1'b0;
  int          long_pulse = 0;

  logic        m_ext, m_brk;
  logic [15:0] m_seq;
  logic [7:0]  m_err;
  logic [31:0] m_word;
  int          m_writes;

  ps2_kb_writer #(
    .KB_INFO_ADDR  (ADDR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb_wraddr(kb_wraddr),
    .kb_wrdata(kb_wrdata),
    .kb_we    (kb_we),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kb_we) begin
      got_q.push_back(kb_wrdata);
      if (we_prev) long_pulse++;
    end
    we_prev = kb_we;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_seq = 0; m_err = 0; m_word = 0; m_writes = 0;
    got_q.delete();
    long_pulse = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    ps2_clk = 1; ps2_data = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 0;
    repeat (half) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_bad);
    ps2_bit(~stop_bad);
    ps2_data = 1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1;
  endtask

  // Event-level model: one byte either errors, sets a prefix, or emits an event.
  task automatic model_byte(input logic [7:0] d, input logic bad);
    m_writes = 0;
    if (bad) begin
      if (m_err != 8'd255) m_err = m_err + 8'd1;
      m_ext = 0; m_brk = 0;
    end else if (d == 8'hE0) begin
      m_ext = 1;
    end else if (d == 8'hF0) begin
      m_brk = 1;
    end else begin
      m_seq = m_seq + 16'd1;
      m_word = {m_seq, 6'b0, m_brk, m_ext, d};
      m_writes = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check_step(input string tag);
    logic [31:0] first;
    check({tag, ".nwr"}, 32'(got_q.size()), 32'(m_writes));
    if (m_writes != 0) begin
      first = (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx;
      check({tag, ".word"}, first, m_word);
    end
    check({tag, ".held"}, kb_wrdata, m_word);
    check({tag, ".err"}, 32'(err_cnt), 32'(m_err));
    check({tag, ".we_len"}, 32'(long_pulse), 32'd0);
    got_q.delete();
    long_pulse = 0;
  endtask

  task automatic do_frame(input logic [7:0] d, input logic par_bad, input logic stop_bad,
                          input string tag);
    send_frame(d, par_bad, stop_bad);
    model_byte(d, par_bad | stop_bad);
    check_step(tag);
  endtask

  task automatic do_timeout(input int nbits, input string tag);
    send_partial(nbits);
    repeat (TMO + 20) @(negedge clk);
    m_writes = 0;
    check_step(tag);
  endtask

  initial begin
    int r;
    logic [7:0] d;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst.we", 32'(kb_we), 32'd0);
    check("rst.wrdata", kb_wrdata, 32'd0);
    check("rst.err", 32'(err_cnt), 32'd0);
    check("rst.addr", kb_wraddr, ADDR);
    rst_n = 1;
    repeat (4) @(negedge clk);

    do_frame(8'h1C, 0, 0, "t1.make");
    check("t1.literal", kb_wrdata, 32'h0001_001C);

    do_frame(8'hF0, 0, 0, "t2.brk");
    do_frame(8'h1C, 0, 0, "t2.release");
    check("t2.literal", kb_wrdata, 32'h0002_021C);

    reset_dut();
    do_frame(8'hE0, 0, 0, "t3.ext");
    do_frame(8'hF0, 0, 0, "t3.brk");
    do_frame(8'h75, 0, 0, "t3.key");
    check("t3.literal", kb_wrdata, 32'h0001_0375);
    do_frame(8'h1C, 0, 0, "t3.clear");
    check("t3.literal2", kb_wrdata, 32'h0002_001C);

    reset_dut();
    do_frame(8'h1C, 1, 0, "t4.badpar");
    check("t4.err1", 32'(err_cnt), 32'd1);
    do_frame(8'h1C, 0, 0, "t4.good");
    check("t4.literal", kb_wrdata, 32'h0001_001C);

    reset_dut();
    do_timeout(5, "t5.timeout");
    do_frame(8'h29, 0, 0, "t5.after");
    check("t5.literal", kb_wrdata, 32'h0001_0029);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 15);
      d = 8'($urandom);
      case (r)
        0:       do_timeout($urandom_range(1, 9), $sformatf("rnd%0d.tmo", i));
        1:       do_frame(d, 1, 0, $sformatf("rnd%0d.par", i));
        2:       do_frame(d, 0, 1, $sformatf("rnd%0d.stop", i));
        3, 4, 5: do_frame(8'hE0, 0, 0, $sformatf("rnd%0d.e0", i));
        6, 7:    do_frame(8'hF0, 0, 0, $sformatf("rnd%0d.f0", i));
        default: do_frame(d, 0, 0, $sformatf("rnd%0d.key", i));
      endcase
    end

    half = 3;
    for (int i = 0; i < 260; i++) begin
      send_frame(8'($urandom), 1, 0);
      model_byte(8'h00, 1);
    end
    half = 8;
    check_step("sat");
    check("sat.literal", 32'(err_cnt), 32'd255);

    force dut.seq = 16'hFFFF;
    @(negedge clk);
    release dut.seq;
    m_seq = 16'hFFFF;
    do_frame(8'h1C, 0, 0, "t6.wrap");
    check("t6.seqzero", 32'(kb_wrdata[31:16]), 32'd0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst_n = 0;
    #1;
    check("t6.mid_we", 32'(kb_we), 32'd0);
    check("t6.mid_wrdata", kb_wrdata, 32'd0);
    check("t6.mid_err", 32'(err_cnt), 32'd0);
    check("t6.mid_addr", kb_wraddr, ADDR);
    ps2_clk = 1; ps2_data = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (2) @(negedge clk);
    do_frame(8'h5A, 0, 0, "t6.restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
